alu_exec_unit: RTL and testbench
================================

ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 Parameter WIDTH, default 64, datapath width in bits; legal values 8..64, even.
REQ-002 Parameter MUL_EN, default 1; 1 enables the iterative MUL opcode, 0 makes MUL an illegal opcode.
REQ-003 One clock and one reset: `clk` is the only clock; `rst_n` is asynchronous and active-low.
REQ-004 Port `clk`, input, 1 bit: rising-edge clock.
REQ-005 Port `rst_n`, input, 1 bit: asynchronous active-low reset.
REQ-006 Port `in_valid`, input, 1 bit: operation request valid.
REQ-007 Port `in_ready`, output, 1 bit: unit accepts a request this cycle.
REQ-008 Port `ALUOp`, input, 2 bits: main-control operation class.
REQ-009 Port `Opcode`, input, 11 bits: instruction opcode field.
REQ-010 Ports `A` and `B`, input, WIDTH bits each: operands.
REQ-011 Port `out_valid`, output, 1 bit: result valid.
REQ-012 Port `out_ready`, input, 1 bit: consumer accepts the result.
REQ-013 Port `ALU_Result`, output, WIDTH bits: registered result.
REQ-014 Ports `Zero`, `Negative`, `Carry`, `Overflow`, output, 1 bit each: registered flags.
REQ-015 Port `Illegal`, output, 1 bit: registered flag set when the decoded opcode is unsupported.

Function
REQ-016 A request shall be accepted on any rising edge where in_valid=1 and in_ready=1; A, B, ALUOp and Opcode shall be captured on that edge.
REQ-017 Decode shall be as follows:
- ALUOp=00: ADD.
- ALUOp=01: PASS_B.
- ALUOp=10 with Opcode 10001011000: ADD.
- ALUOp=10 with Opcode 11001011000: SUB.
- ALUOp=10 with Opcode 10001010000: AND.
- ALUOp=10 with Opcode 10101010000: ORR.
- ALUOp=10 with Opcode 10011011000: MUL.
- ALUOp=11 or any other Opcode: illegal.
REQ-018 ADD and SUB shall be WIDTH-bit two's-complement, computing A+B and A+~B+1 respectively.
- Carry shall be the carry-out of bit WIDTH-1.
- Overflow shall be signed overflow.
REQ-019 For AND, ORR, PASS_B and MUL, Carry and Overflow shall be 0.
REQ-020 For every operation, Zero shall be (ALU_Result==0) and Negative shall be ALU_Result[WIDTH-1].
REQ-021 MUL shall produce the low WIDTH bits of A*B (unsigned shift-add, one bit per cycle), identical to the signed low product.
REQ-022 An illegal operation shall set ALU_Result=0, Illegal=1, Zero=1, and the other flags to 0; it shall be treated as a single-cycle operation.
REQ-023 The state machine shall have three states:
- IDLE: accepting requests.
- MUL_BUSY: iterating the multiply.
- HOLD: result presented, not yet consumed.
REQ-024 IDLE transitions on acceptance:
- Single-cycle operation: result and flags registered on the accept edge, out_valid=1 on the next cycle (latency 1), go to HOLD.
- MUL: go to MUL_BUSY.
REQ-025 MUL_BUSY shall run an iteration counter 0..WIDTH-1.
- On the edge where the counter reaches WIDTH-1, the product is registered, out_valid=1 follows, and the state goes to HOLD.
- MUL latency from the accept edge to out_valid=1 is WIDTH cycles.
REQ-026 In HOLD, the result and all flags shall remain stable while out_valid=1 and out_ready=0.
REQ-027 The result shall be consumed on an edge with out_valid=1 and out_ready=1; after consumption, out_valid=0 unless a new single-cycle result is registered on the same edge.
REQ-028 in_ready = (state==IDLE) OR (state==HOLD AND out_ready=1), so a pass-through of one operation per cycle is possible.
REQ-029 Simultaneous consume and accept in HOLD:
- Single-cycle operation: the new result is loaded on the same edge, out_valid stays 1, state stays HOLD.
- MUL: out_valid goes to 0 and the state goes to MUL_BUSY.
REQ-030 in_ready shall be 0 throughout MUL_BUSY, and in HOLD while out_ready=0.
REQ-031 Operand, ALUOp and Opcode changes while in_ready=0 shall have no effect.
REQ-032 With MUL_EN=0, the MUL_BUSY state and the iteration counter shall be absent.

Reset
REQ-033 While rst_n=0, regardless of clk:
- State=IDLE and the iteration counter=0.
- out_valid=0, ALU_Result=0, and all flags=0.
- in_ready=1.
REQ-034 Reset asserted during MUL_BUSY or HOLD shall abandon the operation; no result shall be produced after reset is released.
REQ-035 The first acceptance shall be possible on the first rising edge after rst_n deasserts.

Verification
REQ-036 With WIDTH=64, ALUOp=10, Opcode=11001011000, A=5, B=5, out_ready=1 -> one cycle later: out_valid=1, ALU_Result=0, Zero=1, Carry=1, Overflow=0.
REQ-037 With WIDTH=64, ADD A=0x7FFFFFFFFFFFFFFF, B=1 -> ALU_Result=0x8000000000000000, Negative=1, Overflow=1, Carry=0.
REQ-038 With WIDTH=64, MUL A=0xFFFFFFFFFFFFFFFF, B=3 -> in_ready=0 for 64 cycles, then out_valid=1 with ALU_Result=0xFFFFFFFFFFFFFFFD.
REQ-039 Back-to-back: AND with out_ready held at 0 for 3 cycles -> result stable and in_ready=0; when out_ready is raised, the queued ORR is accepted on the same edge and its result appears on the next cycle.
REQ-040 ALUOp=10 with Opcode=11111111111 -> Illegal=1, ALU_Result=0, Zero=1; with WIDTH=8 and MUL_EN=0, the MUL opcode also -> Illegal=1.
REQ-041 rst_n pulsed low at MUL cycle 10 -> out_valid=0 and in_ready=1 immediately; no stale result appears after rst_n is released.

Source files
------------

// File: rtl/alu_exec_unit.sv
// Handshaked ALU execution unit: single-cycle ADD/SUB/AND/ORR/PASS_B and an
// optional iterative shift-add MUL, with a registered result held until consumed.
module alu_exec_unit #(
    parameter int unsigned WIDTH  = 64,
    parameter bit          MUL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       ALUOp,
    input  logic [10:0]      Opcode,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALU_Result,
    output logic             Zero,
    output logic             Negative,
    output logic             Carry,
    output logic             Overflow,
    output logic             Illegal
);

    typedef enum logic [1:0] {ST_IDLE, ST_MUL_BUSY, ST_HOLD} state_e;
    typedef enum logic [2:0] {OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_PASSB, OP_MUL, OP_ILL} op_e;

    localparam logic [10:0] OPC_ADD = 11'b10001011000;
    localparam logic [10:0] OPC_SUB = 11'b11001011000;
    localparam logic [10:0] OPC_AND = 11'b10001010000;
    localparam logic [10:0] OPC_ORR = 11'b10101010000;
    localparam logic [10:0] OPC_MUL = 11'b10011011000;

    state_e             state_q, state_d;
    logic               valid_q, valid_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic               zero_q, zero_d;
    logic               neg_q, neg_d;
    logic               carry_q, carry_d;
    logic               ovf_q, ovf_d;
    logic               ill_q, ill_d;

    op_e                op_dec;
    logic               accept;
    logic [WIDTH-1:0]   b_opnd;
    logic [WIDTH:0]     sum_ext;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_carry, alu_ovf, alu_ill;
    logic               mul_done;
    logic [WIDTH-1:0]   mul_prod;

    always_comb begin
        op_dec = OP_ILL;
        case (ALUOp)
            2'b00: op_dec = OP_ADD;
            2'b01: op_dec = OP_PASSB;
            2'b10: begin
                case (Opcode)
                    OPC_ADD: op_dec = OP_ADD;
                    OPC_SUB: op_dec = OP_SUB;
                    OPC_AND: op_dec = OP_AND;
                    OPC_ORR: op_dec = OP_ORR;
                    OPC_MUL: op_dec = MUL_EN ? OP_MUL : OP_ILL;
                    default: op_dec = OP_ILL;
                endcase
            end
            default: op_dec = OP_ILL;
        endcase
    end

    // SUB reuses the adder as A + ~B + 1, so carry means "no borrow".
    always_comb begin
        b_opnd    = (op_dec == OP_SUB) ? ~B : B;
        sum_ext   = {1'b0, A} + {1'b0, b_opnd} + {{WIDTH{1'b0}}, (op_dec == OP_SUB)};
        alu_res   = '0;
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
        alu_ill   = 1'b0;
        case (op_dec)
            OP_ADD, OP_SUB: begin
                alu_res   = sum_ext[WIDTH-1:0];
                alu_carry = sum_ext[WIDTH];
                alu_ovf   = (A[WIDTH-1] == b_opnd[WIDTH-1]) && (alu_res[WIDTH-1] != A[WIDTH-1]);
            end
            OP_AND:   alu_res = A & B;
            OP_ORR:   alu_res = A | B;
            OP_PASSB: alu_res = B;
            OP_ILL:   alu_ill = 1'b1;
            default:  alu_res = '0;
        endcase
    end

    assign in_ready = (state_q == ST_IDLE) || ((state_q == ST_HOLD) && out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        res_d   = res_q;
        zero_d  = zero_q;
        neg_d   = neg_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        ill_d   = ill_q;

        if ((state_q == ST_HOLD) && out_ready) begin
            valid_d = 1'b0;
            state_d = ST_IDLE;
        end

        if ((state_q == ST_MUL_BUSY) && mul_done) begin
            res_d   = mul_prod;
            zero_d  = (mul_prod == '0);
            neg_d   = mul_prod[WIDTH-1];
            carry_d = 1'b0;
            ovf_d   = 1'b0;
            ill_d   = 1'b0;
            valid_d = 1'b1;
            state_d = ST_HOLD;
        end

        // Acceptance may coincide with consumption in HOLD; the new op wins.
        if (accept) begin
            if (op_dec == OP_MUL) begin
                valid_d = 1'b0;
                state_d = ST_MUL_BUSY;
            end else begin
                res_d   = alu_res;
                zero_d  = (alu_res == '0);
                neg_d   = alu_res[WIDTH-1];
                carry_d = alu_carry;
                ovf_d   = alu_ovf;
                ill_d   = alu_ill;
                valid_d = 1'b1;
                state_d = ST_HOLD;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
            res_q   <= '0;
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
            neg_q   <= neg_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            ill_q   <= ill_d;
        end
    end

    if (MUL_EN) begin : g_mul
        localparam int unsigned CW = $clog2(WIDTH);
        logic [CW-1:0]    cnt_q;
        logic [WIDTH-1:0] acc_q, mcand_q, mplier_q;
        logic [WIDTH-1:0] partial;
        logic             mul_start;

        assign mul_start = accept && (op_dec == OP_MUL);
        assign partial   = acc_q + (mplier_q[0] ? mcand_q : '0);
        assign mul_prod  = partial;
        // Bit 0 is folded in on the accept edge, so the counter hits WIDTH-1
        // on the edge that adds the last partial product.
        assign mul_done  = (state_q == ST_MUL_BUSY) && (cnt_q == CW'(WIDTH - 2));

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q    <= '0;
                acc_q    <= '0;
                mcand_q  <= '0;
                mplier_q <= '0;
            end else if (mul_start) begin
                cnt_q    <= '0;
                acc_q    <= B[0] ? A : '0;
                mcand_q  <= A << 1;
                mplier_q <= B >> 1;
            end else if (state_q == ST_MUL_BUSY) begin
                cnt_q    <= cnt_q + CW'(1);
                acc_q    <= partial;
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_q >> 1;
            end
        end
    end else begin : g_no_mul
        assign mul_done = 1'b0;
        assign mul_prod = '0;
    end

    assign out_valid  = valid_q;
    assign ALU_Result = res_q;
    assign Zero       = zero_q;
    assign Negative   = neg_q;
    assign Carry      = carry_q;
    assign Overflow   = ovf_q;
    assign Illegal    = ill_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed table, handshake corner
// sequences and random ops against an arithmetic reference model.
module tb_alu_exec_unit;

    localparam logic [10:0] OPC_ADD = 11'b10001011000;
    localparam logic [10:0] OPC_SUB = 11'b11001011000;
    localparam logic [10:0] OPC_AND = 11'b10001010000;
    localparam logic [10:0] OPC_ORR = 11'b10101010000;
    localparam logic [10:0] OPC_MUL = 11'b10011011000;
    localparam logic [10:0] OPC_BAD = 11'b11111111111;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic        in_valid, in_ready, out_valid, out_ready;
    logic [1:0]  aluop;
    logic [10:0] opcode;
    logic [63:0] a, b, res;
    logic        z, n, c, v, ill;

    logic        in_valid8, in_ready8, out_valid8, out_ready8;
    logic [1:0]  aluop8;
    logic [10:0] opcode8;
    logic [7:0]  a8, b8, res8;
    logic        z8, n8, c8, v8, ill8;

    alu_exec_unit #(.WIDTH(64), .MUL_EN(1'b1)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .ALUOp(aluop), .Opcode(opcode), .A(a), .B(b),
        .out_valid(out_valid), .out_ready(out_ready), .ALU_Result(res),
        .Zero(z), .Negative(n), .Carry(c), .Overflow(v), .Illegal(ill)
    );

    alu_exec_unit #(.WIDTH(8), .MUL_EN(1'b0)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .ALUOp(aluop8), .Opcode(opcode8), .A(a8), .B(b8),
        .out_valid(out_valid8), .out_ready(out_ready8), .ALU_Result(res8),
        .Zero(z8), .Negative(n8), .Carry(c8), .Overflow(v8), .Illegal(ill8)
    );

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [1:0]  op;
        logic [10:0] opc;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] res;
        logic [4:0]  fl;   // {Zero, Negative, Carry, Overflow, Illegal}
        int          lat;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mkv(input logic [1:0] op, input logic [10:0] opc,
                                 input logic [63:0] a_, input logic [63:0] b_,
                                 input logic [63:0] r, input logic [4:0] f, input int l);
        vec_t e;
        e.op = op; e.opc = opc; e.a = a_; e.b = b_; e.res = r; e.fl = f; e.lat = l;
        return e;
    endfunction

    // Reference: decode table, then plain integer arithmetic on the operands.
    function automatic vec_t model(input logic [1:0] op, input logic [10:0] opc,
                                   input logic [63:0] a_, input logic [63:0] b_);
        vec_t e;
        int k;
        logic signed [64:0] s;
        logic cy, ov, il;
        e.op = op; e.opc = opc; e.a = a_; e.b = b_; e.lat = 1;
        cy = 1'b0; ov = 1'b0; il = 1'b0;
        if (op == 2'b00) k = 0;
        else if (op == 2'b01) k = 4;
        else if (op == 2'b10) begin
            if (opc == OPC_ADD) k = 0;
            else if (opc == OPC_SUB) k = 1;
            else if (opc == OPC_AND) k = 2;
            else if (opc == OPC_ORR) k = 3;
            else if (opc == OPC_MUL) k = 5;
            else k = 6;
        end else k = 6;
        case (k)
            0: begin
                e.res = a_ + b_;
                cy = ({1'b0, a_} + {1'b0, b_}) > 65'h0_FFFF_FFFF_FFFF_FFFF;
                s = $signed({a_[63], a_}) + $signed({b_[63], b_});
                ov = (s[64] != s[63]);
            end
            1: begin
                e.res = a_ - b_;
                cy = (a_ >= b_);
                s = $signed({a_[63], a_}) - $signed({b_[63], b_});
                ov = (s[64] != s[63]);
            end
            2: e.res = a_ & b_;
            3: e.res = a_ | b_;
            4: e.res = b_;
            5: begin e.res = a_ * b_; e.lat = 64; end
            default: begin e.res = '0; il = 1'b1; end
        endcase
        e.fl = {(e.res == 64'd0), e.res[63], cy, ov, il};
        return e;
    endfunction

    function automatic logic [63:0] rnd64();
        case ($urandom_range(0, 5))
            0: return 64'd0;
            1: return '1;
            2: return 64'h8000_0000_0000_0000;
            3: return 64'h7FFF_FFFF_FFFF_FFFF;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    task automatic apply64(input vec_t e, input int hold);
        int lat;
        chk("in_ready_idle", in_ready, 1);
        aluop = e.op; opcode = e.opc; a = e.a; b = e.b;
        in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = {$urandom, $urandom}; b = {$urandom, $urandom};
        aluop = 2'($urandom); opcode = 11'($urandom);
        lat = 1;
        while (!out_valid && lat < 200) begin
            chk("busy_in_ready", in_ready, 0);
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", lat, e.lat);
        chk("result", res, e.res);
        chk("flags", {z, n, c, v, ill}, e.fl);
        for (int i = 0; i < hold; i++) begin
            chk("hold_in_ready", in_ready, 0);
            @(posedge clk); #1;
            chk("hold_valid", out_valid, 1);
            chk("hold_result", res, e.res);
            chk("hold_flags", {z, n, c, v, ill}, e.fl);
        end
        out_ready = 1'b1;
        #1;
        chk("hold_ready_pass", in_ready, 1);
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("consumed", out_valid, 0);
    endtask

    task automatic apply8(input string nm, input logic [1:0] op, input logic [10:0] opc,
                          input logic [7:0] a_, input logic [7:0] b_,
                          input logic [7:0] er, input logic [4:0] ef);
        aluop8 = op; opcode8 = opc; a8 = a_; b8 = b_;
        in_valid8 = 1'b1; out_ready8 = 1'b0;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        chk({nm, "_valid"}, out_valid8, 1);
        chk({nm, "_result"}, res8, er);
        chk({nm, "_flags"}, {z8, n8, c8, v8, ill8}, ef);
        out_ready8 = 1'b1;
        @(posedge clk); #1;
        out_ready8 = 1'b0;
        chk({nm, "_consumed"}, out_valid8, 0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation time limit");
    end

    initial begin
        vec_t tbl[15];
        vec_t e;
        int lat, seen;
        logic [1:0] op;
        logic [10:0] opc;

        tbl[0]  = mkv(2'b10, OPC_SUB, 64'd5, 64'd5, 64'd0, 5'b10100, 1);
        tbl[1]  = mkv(2'b00, 11'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h8000_0000_0000_0000, 5'b01010, 1);
        tbl[2]  = mkv(2'b10, OPC_MUL, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 64'hFFFF_FFFF_FFFF_FFFD, 5'b01000, 64);
        tbl[3]  = mkv(2'b10, OPC_AND, 64'hF0F0_F0F0_F0F0_F0F0, 64'h0FF0_0FF0_0FF0_0FF0, 64'h00F0_00F0_00F0_00F0, 5'b00000, 1);
        tbl[4]  = mkv(2'b10, OPC_ORR, 64'hF0F0_F0F0_F0F0_F0F0, 64'h0FF0_0FF0_0FF0_0FF0, 64'hFFF0_FFF0_FFF0_FFF0, 5'b01000, 1);
        tbl[5]  = mkv(2'b01, OPC_SUB, 64'd123, 64'd0, 64'd0, 5'b10000, 1);
        tbl[6]  = mkv(2'b11, OPC_ADD, 64'd1, 64'd2, 64'd0, 5'b10001, 1);
        tbl[7]  = mkv(2'b10, OPC_BAD, 64'd5, 64'd6, 64'd0, 5'b10001, 1);
        tbl[8]  = mkv(2'b10, OPC_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 5'b10100, 1);
        tbl[9]  = mkv(2'b10, OPC_SUB, 64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 5'b01000, 1);
        tbl[10] = mkv(2'b10, OPC_SUB, 64'h8000_0000_0000_0000, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 5'b00110, 1);
        tbl[11] = mkv(2'b10, OPC_MUL, 64'h1_0000_0001, 64'h1_0000_0001, 64'h0000_0002_0000_0001, 5'b00000, 64);
        tbl[12] = mkv(2'b10, OPC_MUL, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD, 64'd6, 5'b00000, 64);
        tbl[13] = mkv(2'b00, OPC_BAD, 64'd2, 64'd3, 64'd5, 5'b00000, 1);
        tbl[14] = mkv(2'b10, OPC_MUL, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 5'b10000, 64);

        in_valid = 1'b0; out_ready = 1'b0; aluop = '0; opcode = '0; a = '0; b = '0;
        in_valid8 = 1'b0; out_ready8 = 1'b0; aluop8 = '0; opcode8 = '0; a8 = '0; b8 = '0;

        #2 rst_n = 1'b0;
        #10;
        chk("rst_valid", out_valid, 0);
        chk("rst_ready", in_ready, 1);
        chk("rst_result", res, 0);
        chk("rst_flags", {z, n, c, v, ill}, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid_clk", out_valid, 0);
        chk("rst_ready_clk", in_ready, 1);
        chk("rst8_valid", out_valid8, 0);
        chk("rst8_flags", {z8, n8, c8, v8, ill8}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // First vector is accepted on the very first edge after release.
        foreach (tbl[i]) apply64(tbl[i], i % 3);

        apply8("w8_mul_illegal", 2'b10, OPC_MUL, 8'd3, 8'd5, 8'h00, 5'b10001);
        apply8("w8_add_ovf", 2'b00, 11'd0, 8'h7F, 8'h01, 8'h80, 5'b01010);
        apply8("w8_sub_zero", 2'b10, OPC_SUB, 8'd5, 8'd5, 8'h00, 5'b10100);
        apply8("w8_add_carry", 2'b10, OPC_ADD, 8'hFF, 8'h01, 8'h00, 5'b10100);
        apply8("w8_bad_opc", 2'b10, OPC_BAD, 8'd9, 8'd9, 8'h00, 5'b10001);

        // AND held for 3 cycles with an ORR waiting; ORR accepted on release edge.
        aluop = 2'b10; opcode = OPC_AND; a = 64'hFF00_FF00_FF00_FF00; b = 64'h0F0F_0F0F_0F0F_0F0F;
        in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        opcode = OPC_ORR; a = 64'd1; b = 64'd2;
        for (int i = 0; i < 3; i++) begin
            chk("b2b_hold_valid", out_valid, 1);
            chk("b2b_hold_ready", in_ready, 0);
            chk("b2b_hold_result", res, 64'h0F00_0F00_0F00_0F00);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        #1;
        chk("b2b_ready_pass", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("b2b_orr_valid", out_valid, 1);
        chk("b2b_orr_result", res, 64'd3);
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("b2b_drain", out_valid, 0);

        // One op per cycle with the consumer always ready.
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            aluop = 2'b00; a = 64'(i * 100 + 7); b = 64'(i);
            in_valid = 1'b1;
            @(posedge clk); #1;
            chk("pt_valid", out_valid, 1);
            chk("pt_result", res, 64'(i * 101 + 7));
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("pt_drain", out_valid, 0);
        out_ready = 1'b0;

        // Consume in HOLD while accepting a MUL.
        aluop = 2'b00; a = 64'd1; b = 64'd1; in_valid = 1'b1;
        @(posedge clk); #1;
        chk("hm_add_result", res, 64'd2);
        aluop = 2'b10; opcode = OPC_MUL; a = 64'hFFFF_FFFF_FFFF_FFFE; b = 64'hFFFF_FFFF_FFFF_FFFD;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b0;
        chk("hm_valid_drop", out_valid, 0);
        chk("hm_busy_ready", in_ready, 0);
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("hm_latency", lat, 64);
        chk("hm_result", res, 64'd6);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        for (int t = 0; t < 150; t++) begin
            case ($urandom_range(0, 7))
                0: begin op = 2'b00; opc = 11'($urandom); end
                1: begin op = 2'b01; opc = 11'($urandom); end
                2: begin op = 2'b10; opc = OPC_ADD; end
                3: begin op = 2'b10; opc = OPC_SUB; end
                4: begin op = 2'b10; opc = OPC_AND; end
                5: begin op = 2'b10; opc = OPC_ORR; end
                6: begin op = 2'b10; opc = OPC_MUL; end
                default: begin op = 2'($urandom_range(2, 3)); opc = 11'($urandom); end
            endcase
            e = model(op, opc, rnd64(), rnd64());
            apply64(e, $urandom_range(0, 2));
        end

        // Reset 10 cycles into a MUL: operation must vanish.
        aluop = 2'b10; opcode = OPC_MUL; a = 64'd12345; b = 64'd678;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        chk("mrst_busy", in_ready, 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mrst_valid", out_valid, 0);
        chk("mrst_ready", in_ready, 1);
        chk("mrst_result", res, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (80) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        chk("mrst_stale", seen, 0);
        chk("mrst_ready_after", in_ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
